alarm_ctrl: RTL and testbench
=============================

// Module: alarm_ctrl
// PURPOSE
//  Downstream consumer of the alarm-match pulse H from the time-compare stage.
//  Runs the ring/snooze/stop FSM and drives the buzzer square wave and status LEDs.
//  Sits between the compare stage and the board outputs (buzzer pin, LEDs).
// PARAMETERS
//  CLK_HZ      100_000_000  system clock frequency (Hz)
//  TONE_HZ     2_000        buzzer tone frequency (Hz); half-period HP = CLK_HZ/(2*TONE_HZ)
//  RING_SEC    60           seconds of ringing before auto-stop (>=1)
//  SNOOZE_SEC  300          snooze duration in seconds (>=1)
//  MAX_SNOOZE  3            snoozes allowed per alarm event (>=1)
// PORTS
//  clk          in   1  system clock
//  rst          in   1  synchronous, active-high reset
//  H            in   1  1-cycle alarm-match pulse
//  sec_tick     in   1  1-cycle pulse once per second, from the time counter
//  alarm_en     in   1  alarm arm switch (level, pre-synchronised)
//  stop_p       in   1  stop button, debounced 1-cycle pulse
//  snooze_p     in   1  snooze button, debounced 1-cycle pulse
//  ringing      out  1  1 while in RING
//  snoozing     out  1  1 while in SNOOZE
//  buzzer       out  1  square wave at TONE_HZ while ringing, else 0
//  led_alarm    out  1  alarm status LED
//  snooze_left  out  $clog2(MAX_SNOOZE+1)  snoozes remaining
// BEHAVIOUR
//  Reset: state=IDLE; ringing=snoozing=buzzer=led_alarm=0; snooze_left=MAX_SNOOZE; all counters 0.
//  States: IDLE, RING, SNOOZE. Per-cycle priority: rst > !alarm_en > stop_p > snooze_p > sec_tick > H.
//  IDLE:   H && alarm_en -> RING; ring_sec=0; snooze_left=MAX_SNOOZE. H with !alarm_en is ignored.
//  RING:   stop_p -> IDLE.
//          snooze_p && snooze_left>0 -> SNOOZE; snooze_left-1; snz_sec=0.
//          snooze_p && snooze_left==0 -> ignored, remain in RING.
//          sec_tick: ring_sec+1; tick when ring_sec==RING_SEC-1 -> IDLE (timeout).
//  SNOOZE: stop_p -> IDLE. sec_tick: snz_sec+1; tick when snz_sec==SNOOZE_SEC-1 -> RING, ring_sec=0.
//  !alarm_en in any state -> IDLE next cycle.
//  H in RING/SNOOZE is ignored; it does not restart counters.
//  Latency: ringing/snoozing are decoded from the state register, so they rise 1 cycle after the causing pulse.
//  Tone: cycle counter runs only in RING; buzzer toggles every HP cycles.
//    Entering RING: counter=0, buzzer=0. Leaving RING: buzzer forced 0 the same cycle the state leaves.
//  Stop or timeout ends the event; snooze_left is reloaded only on the next accepted H.
//  Counters saturate-safe: widths $clog2(RING_SEC), $clog2(SNOOZE_SEC), $clog2(HP); no wrap in normal use.
// CONFIGURATION
//  ALARM_CTRL_BLINK_EN defined:
//    led_alarm blinks at 2 Hz in RING (toggled every CLK_HZ/4 cycles, starts at 1).
//    led_alarm is a steady 1 in SNOOZE and 0 in IDLE.
//  Undefined: led_alarm = ringing | snoozing (steady); no blink counter synthesised.
// STRUCTURE
//  alarm_pkg: typedef enum logic [1:0] {IDLE, RING, SNOOZE} alarm_state_t;
//    also localparam function for half-period computation.
//  Sub-module tone_gen (clk, rst, en, HP param -> sq):
//    resettable square-wave divider; clears to 0 when en=0.
//    Reused for the blink divider when ALARM_CTRL_BLINK_EN is defined.
// TESTING  (CLK_HZ=1000, TONE_HZ=100 -> HP=5, RING_SEC=3, SNOOZE_SEC=2, MAX_SNOOZE=2)
//  1 alarm_en=1, H pulse -> ringing=1 next cycle; buzzer 0 for 5 cycles, then 1 for 5, period 10.
//  2 In RING, 3 sec_ticks and no buttons -> IDLE after the 3rd tick; ringing=0, buzzer=0.
//  3 In RING, snooze_p -> snoozing=1, snooze_left=1; after 2 ticks -> ringing=1.
//    Repeat snooze -> snooze_left=0; a 3rd snooze_p is ignored, state stays RING.
//  4 stop_p and snooze_p in the same cycle in RING -> IDLE.
//    sec_tick coincident with stop_p in SNOOZE -> IDLE.
//  5 alarm_en=0 then H -> stays IDLE. alarm_en drops mid-SNOOZE -> IDLE next cycle.
//  6 rst asserted mid-RING -> all outputs at reset values next cycle; H during RING does not extend ringing.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and elaboration-time helpers for the alarm controller.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } alarm_state_t;

  function automatic int half_period(input int clk_hz, input int tone_hz);
    return clk_hz / (2 * tone_hz);
  endfunction

  // Counter width able to hold 0..n-1; never collapses to zero bits.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/alarm_ctrl_tone_gen.sv
// Square-wave divider: sq toggles every HP enabled cycles, held at 0 while en=0.
module tone_gen
  import alarm_pkg::*;
#(
  parameter int HP = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sq
);

  localparam int W = cnt_w(HP);
  localparam logic [W-1:0] LAST = W'(HP - 1);

  logic [W-1:0] cnt_q;
  logic         sq_q;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt_q <= '0;
      sq_q  <= 1'b0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
      sq_q  <= ~sq_q;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign sq = sq_q;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm ring/snooze/stop controller driving the buzzer tone and status LED.
// Optional feature macro: ALARM_CTRL_BLINK_EN (2 Hz LED blink while ringing).
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TONE_HZ    = 2_000,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          H,
  input  logic                          sec_tick,
  input  logic                          alarm_en,
  input  logic                          stop_p,
  input  logic                          snooze_p,
  output logic                          ringing,
  output logic                          snoozing,
  output logic                          buzzer,
  output logic                          led_alarm,
  output logic [$clog2(MAX_SNOOZE+1)-1:0] snooze_left
);

  localparam int HP = half_period(CLK_HZ, TONE_HZ);
  localparam int RW = cnt_w(RING_SEC);
  localparam int SW = cnt_w(SNOOZE_SEC);
  localparam int LW = $clog2(MAX_SNOOZE + 1);

  localparam logic [RW-1:0] RING_LAST   = RW'(RING_SEC - 1);
  localparam logic [SW-1:0] SNOOZE_LAST = SW'(SNOOZE_SEC - 1);
  localparam logic [LW-1:0] LEFT_INIT   = LW'(MAX_SNOOZE);

  alarm_state_t  state_q;
  logic [RW-1:0] ring_sec_q;
  logic [SW-1:0] snz_sec_q;
  logic [LW-1:0] left_q;
  logic          tone_sq;

  // The if/else chain encodes the input priority: disarm, stop, snooze, tick, match.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ring_sec_q <= '0;
      snz_sec_q  <= '0;
      left_q     <= LEFT_INIT;
    end else if (!alarm_en) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (H) begin
            state_q    <= RING;
            ring_sec_q <= '0;
            left_q     <= LEFT_INIT;
          end
        end
        RING: begin
          if (stop_p) begin
            state_q <= IDLE;
          end else if (snooze_p && left_q != '0) begin
            state_q   <= SNOOZE;
            left_q    <= left_q - LW'(1);
            snz_sec_q <= '0;
          end else if (sec_tick) begin
            if (ring_sec_q == RING_LAST) state_q <= IDLE;
            else                         ring_sec_q <= ring_sec_q + RW'(1);
          end
        end
        SNOOZE: begin
          if (stop_p) begin
            state_q <= IDLE;
          end else if (sec_tick) begin
            if (snz_sec_q == SNOOZE_LAST) begin
              state_q    <= RING;
              ring_sec_q <= '0;
            end else begin
              snz_sec_q <= snz_sec_q + SW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ringing     = (state_q == RING);
  assign snoozing    = (state_q == SNOOZE);
  assign snooze_left = left_q;

  tone_gen #(.HP(HP)) u_tone (
    .clk (clk),
    .rst (rst),
    .en  (ringing),
    .sq  (tone_sq)
  );

  // Masking with ringing silences the pin in the very cycle the state leaves RING.
  assign buzzer = tone_sq & ringing;

`ifdef ALARM_CTRL_BLINK_EN
  logic blink_sq;

  tone_gen #(.HP(CLK_HZ / 4)) u_blink (
    .clk (clk),
    .rst (rst),
    .en  (ringing),
    .sq  (blink_sq)
  );

  assign led_alarm = ringing ? ~blink_sq : snoozing;
`else
  assign led_alarm = ringing | snoozing;
`endif

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl with a behavioural reference checked every cycle.
module tb_alarm_ctrl;

  localparam int CLK_HZ     = 1000;
  localparam int TONE_HZ    = 100;
  localparam int RING_SEC   = 3;
  localparam int SNOOZE_SEC = 2;
  localparam int MAX_SNOOZE = 2;
  localparam int HALF       = CLK_HZ / (2 * TONE_HZ);
  localparam int LW         = $clog2(MAX_SNOOZE + 1);

  localparam int M_IDLE   = 0;
  localparam int M_RING   = 1;
  localparam int M_SNOOZE = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          H = 1'b0, sec_tick = 1'b0, alarm_en = 1'b1;
  logic          stop_p = 1'b0, snooze_p = 1'b0;
  logic          ringing, snoozing, buzzer, led_alarm;
  logic [LW-1:0] snooze_left;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Reference model state.
  int m_mode = M_IDLE;
  int m_left = MAX_SNOOZE;
  int m_rsec = 0;
  int m_ssec = 0;
  int m_ring_cycles = 0;

  alarm_ctrl #(
    .CLK_HZ(CLK_HZ), .TONE_HZ(TONE_HZ), .RING_SEC(RING_SEC),
    .SNOOZE_SEC(SNOOZE_SEC), .MAX_SNOOZE(MAX_SNOOZE)
  ) dut (
    .clk(clk), .rst(rst), .H(H), .sec_tick(sec_tick), .alarm_en(alarm_en),
    .stop_p(stop_p), .snooze_p(snooze_p), .ringing(ringing), .snoozing(snoozing),
    .buzzer(buzzer), .led_alarm(led_alarm), .snooze_left(snooze_left)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: evaluates the rules on the inputs present at each rising edge.
  always @(posedge clk) begin
    int prev;
    prev = m_mode;
    if (rst) begin
      m_mode = M_IDLE; m_left = MAX_SNOOZE; m_rsec = 0; m_ssec = 0;
    end else if (!alarm_en) begin
      m_mode = M_IDLE;
    end else if (m_mode == M_IDLE) begin
      if (H) begin m_mode = M_RING; m_rsec = 0; m_left = MAX_SNOOZE; end
    end else if (m_mode == M_RING) begin
      if (stop_p) m_mode = M_IDLE;
      else if (snooze_p && m_left > 0) begin
        m_mode = M_SNOOZE; m_left = m_left - 1; m_ssec = 0;
      end else if (sec_tick) begin
        m_rsec = m_rsec + 1;
        if (m_rsec >= RING_SEC) m_mode = M_IDLE;
      end
    end else begin
      if (stop_p) m_mode = M_IDLE;
      else if (sec_tick) begin
        m_ssec = m_ssec + 1;
        if (m_ssec >= SNOOZE_SEC) begin m_mode = M_RING; m_rsec = 0; end
      end
    end
    if (m_mode == M_RING && prev == M_RING && !rst) m_ring_cycles = m_ring_cycles + 1;
    else m_ring_cycles = 0;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int exp_buz, exp_led;
      exp_buz = (m_mode == M_RING) ? ((m_ring_cycles / HALF) % 2) : 0;
`ifdef ALARM_CTRL_BLINK_EN
      exp_led = (m_mode == M_RING) ? (((m_ring_cycles / (CLK_HZ / 4)) % 2) == 0 ? 1 : 0)
                                   : (m_mode == M_SNOOZE ? 1 : 0);
`else
      exp_led = (m_mode != M_IDLE) ? 1 : 0;
`endif
      chk("model_ringing", int'(ringing), (m_mode == M_RING) ? 1 : 0);
      chk("model_snoozing", int'(snoozing), (m_mode == M_SNOOZE) ? 1 : 0);
      chk("model_buzzer", int'(buzzer), exp_buz);
      chk("model_led", int'(led_alarm), exp_led);
      chk("model_snooze_left", int'(snooze_left), m_left);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    H = 1'b0; sec_tick = 1'b0; stop_p = 1'b0; snooze_p = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    steps(3);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_ringing", int'(ringing), 0);
    chk("reset_snoozing", int'(snoozing), 0);
    chk("reset_buzzer", int'(buzzer), 0);
    chk("reset_led", int'(led_alarm), 0);
    chk("reset_left", int'(snooze_left), MAX_SNOOZE);
    $display("T0 reset released");

    // 1: ring starts one cycle after H; tone 0 for 5 cycles, then 1 for 5.
    H = 1'b1; step();
    chk("t1_ringing", int'(ringing), 1);
    for (int i = 0; i < 20; i++) begin
      chk("t1_buzzer", int'(buzzer), (i / 5) % 2);
      step();
    end
    stop_p = 1'b1; step();
    chk("t1_stop_ringing", int'(ringing), 0);
    chk("t1_stop_buzzer", int'(buzzer), 0);
    $display("T1 ring tone and stop");

    // 2: timeout after the third second tick.
    H = 1'b1; step();
    for (int k = 0; k < 3; k++) begin
      steps(2);
      chk("t2_ringing_before_tick", int'(ringing), 1);
      sec_tick = 1'b1; step();
    end
    chk("t2_timeout_ringing", int'(ringing), 0);
    chk("t2_timeout_buzzer", int'(buzzer), 0);
    $display("T2 ring timeout");

    // 3: snooze twice, third snooze ignored.
    H = 1'b1; step();
    snooze_p = 1'b1; step();
    chk("t3_snoozing", int'(snoozing), 1);
    chk("t3_left1", int'(snooze_left), 1);
    sec_tick = 1'b1; step();
    chk("t3_still_snoozing", int'(snoozing), 1);
    sec_tick = 1'b1; step();
    chk("t3_back_ringing", int'(ringing), 1);
    snooze_p = 1'b1; step();
    chk("t3_left0", int'(snooze_left), 0);
    sec_tick = 1'b1; step();
    sec_tick = 1'b1; step();
    chk("t3_ring_again", int'(ringing), 1);
    snooze_p = 1'b1; step();
    chk("t3_ignored_ringing", int'(ringing), 1);
    chk("t3_ignored_snoozing", int'(snoozing), 0);
    stop_p = 1'b1; step();
    $display("T3 snooze exhaustion");

    // 4: stop beats snooze in RING; stop beats tick in SNOOZE.
    H = 1'b1; step();
    chk("t4_reload_left", int'(snooze_left), MAX_SNOOZE);
    stop_p = 1'b1; snooze_p = 1'b1; step();
    chk("t4_stop_snooze_ringing", int'(ringing), 0);
    chk("t4_stop_snooze_snoozing", int'(snoozing), 0);
    H = 1'b1; step();
    snooze_p = 1'b1; step();
    stop_p = 1'b1; sec_tick = 1'b1; step();
    chk("t4_stop_tick_snoozing", int'(snoozing), 0);
    chk("t4_stop_tick_ringing", int'(ringing), 0);
    $display("T4 stop priority");

    // 5: disarmed alarm ignores H; disarm mid-snooze returns to IDLE.
    alarm_en = 1'b0; H = 1'b1; step();
    chk("t5_disarmed_ringing", int'(ringing), 0);
    alarm_en = 1'b1; H = 1'b1; step();
    snooze_p = 1'b1; step();
    chk("t5_snoozing", int'(snoozing), 1);
    alarm_en = 1'b0; step();
    chk("t5_disarm_snoozing", int'(snoozing), 0);
    alarm_en = 1'b1; step();
    $display("T5 alarm_en handling");

    // 6: H during RING does not extend it; reset mid-RING.
    H = 1'b1; step();
    sec_tick = 1'b1; step();
    H = 1'b1; step();
    sec_tick = 1'b1; step();
    chk("t6_ring_mid", int'(ringing), 1);
    sec_tick = 1'b1; step();
    chk("t6_no_extend", int'(ringing), 0);
    H = 1'b1; step();
    steps(7);
    rst = 1'b1; step();
    chk("t6_rst_ringing", int'(ringing), 0);
    chk("t6_rst_buzzer", int'(buzzer), 0);
    chk("t6_rst_led", int'(led_alarm), 0);
    chk("t6_rst_left", int'(snooze_left), MAX_SNOOZE);
    rst = 1'b0; steps(2);
    $display("T6 reset mid-ring");

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
